// File: rtl/qr_cordic_pkg.sv
// Shared definitions for the CORDIC QR systolic array (GG and GR cells).
// Holds the datapath widths, the CORDIC gain constant, the cell FSM state
// encoding and the two's-complement saturation helper used by every
// micro-rotation stage.
package qr_cordic_pkg;

    localparam int DATA_WIDTH = 20;  // signed data width
    localparam int D_WIDTH    = 4;   // direction bits per beat
    localparam int ITER_NUM   = 12;  // micro-rotations per vector
    localparam int K_WIDTH    = 11;  // width of the gain constant
    localparam int SHIFT_W    = $clog2(ITER_NUM);

    // CORDIC gain 1/1.6468 as unsigned Q1.10 (621/1024).
    localparam logic [K_WIDTH-1:0] K = 11'b0_1001101101;

    // IDLE waits for a sample, ROT consumes direction beats, OUT is the
    // scale-and-write-back step.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROT  = 2'd1,
        ST_OUT  = 2'd2
    } cordic_state_e;

    // Clamp a DATA_WIDTH+1 bit sum back into DATA_WIDTH bits. The sum has
    // overflowed exactly when its two top bits differ.
    function automatic logic signed [DATA_WIDTH-1:0] sat(
        input logic signed [DATA_WIDTH:0] v
    );
        if (v[DATA_WIDTH] != v[DATA_WIDTH-1]) begin
            return v[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                 : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        return v[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/cordic_rot_stage.sv
// One saturating CORDIC micro-rotation, shared by the GG and GR cells.
// Ports:
//   x_i, y_i  input vector
//   d_i       direction: 1 -> x+(y>>>s), y-(x>>>s); 0 -> x-(y>>>s), y+(x>>>s)
//   shift_i   iteration index s
//   x_o, y_o  rotated vector, each clamped to the DATA_WIDTH range
// Purely combinational; the cells chain several of these per clock.
module cordic_rot_stage #(
    parameter int DATA_WIDTH = qr_cordic_pkg::DATA_WIDTH,
    parameter int SHIFT_W    = qr_cordic_pkg::SHIFT_W
) (
    input  logic signed [DATA_WIDTH-1:0] x_i,
    input  logic signed [DATA_WIDTH-1:0] y_i,
    input  logic                         d_i,
    input  logic        [SHIFT_W-1:0]    shift_i,
    output logic signed [DATA_WIDTH-1:0] x_o,
    output logic signed [DATA_WIDTH-1:0] y_o
);
    import qr_cordic_pkg::*;

    logic signed [DATA_WIDTH-1:0] x_sh;
    logic signed [DATA_WIDTH-1:0] y_sh;
    logic signed [DATA_WIDTH:0]   x_sum;
    logic signed [DATA_WIDTH:0]   y_sum;

    dynamic_shift #(.WIDTH(DATA_WIDTH), .SHIFT_W(SHIFT_W)) u_shift_x (
        .data_i  (x_i),
        .shift_i (shift_i),
        .data_o  (x_sh)
    );

    dynamic_shift #(.WIDTH(DATA_WIDTH), .SHIFT_W(SHIFT_W)) u_shift_y (
        .data_i  (y_i),
        .shift_i (shift_i),
        .data_o  (y_sh)
    );

    // One guard bit so the add itself cannot wrap before saturation.
    always_comb begin
        if (d_i) begin
            x_sum = {x_i[DATA_WIDTH-1], x_i} + {y_sh[DATA_WIDTH-1], y_sh};
            y_sum = {y_i[DATA_WIDTH-1], y_i} - {x_sh[DATA_WIDTH-1], x_sh};
        end else begin
            x_sum = {x_i[DATA_WIDTH-1], x_i} - {y_sh[DATA_WIDTH-1], y_sh};
            y_sum = {y_i[DATA_WIDTH-1], y_i} + {x_sh[DATA_WIDTH-1], x_sh};
        end
    end

    assign x_o = sat(x_sum);
    assign y_o = sat(y_sum);

endmodule

// File: rtl/dynamic_shift.sv
// Arithmetic right shift by a run-time amount.
// Ports:
//   data_i   signed operand
//   shift_i  shift amount
//   data_o   data_i >>> shift_i (sign-filling)
module dynamic_shift #(
    parameter int WIDTH   = 20,
    parameter int SHIFT_W = 4
) (
    input  logic signed [WIDTH-1:0]   data_i,
    input  logic        [SHIFT_W-1:0] shift_i,
    output logic signed [WIDTH-1:0]   data_o
);

    assign data_o = data_i >>> shift_i;

endmodule

// File: rtl/gr_cell.sv
// Givens-rotation cell of the CORDIC QR systolic array. Applies the
// rotation directions produced by the GG cell to (stored r_ij, incoming
// a_ij), keeps the rotated r_ij and passes the K-scaled rotated element down.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   clr_i              drop stored r and the first-sample flag, abort rotation
//   valid_i, a_ij      one-cycle sample from the row above (ignored when busy_o)
//   d_valid_i, d_i     direction beat; bit j is iteration D_WIDTH*beat+j
//   busy_o             rotation in progress
//   valid_o            one-cycle pulse: a_o and rij_o carry a new result
//   a_o, rij_o         scaled rotated y, current stored r
//   d_valid_o, d_o     direction beat forwarded one cycle later
// Handshake: there is no back-pressure. valid_i is a qualifier that is only
// honoured while busy_o is low; d_valid_i qualifies each direction beat and
// may be held low for any number of cycles; valid_o is a single-cycle strobe
// the consumer must take when it appears.
// The first sample after rst/clr only loads r. Each later sample starts a
// rotation of D_WIDTH chained micro-rotations per beat. The K scaling and
// write-back are folded into the clock edge that consumes the final beat,
// so the result is registered one cycle after the last beat and the cell is
// already back in ST_IDLE, ready for the next sample, in that same cycle;
// ST_OUT is never held for a cycle here.
module gr_cell #(
    parameter int                DATA_WIDTH = qr_cordic_pkg::DATA_WIDTH,
    parameter int                D_WIDTH    = qr_cordic_pkg::D_WIDTH,
    parameter int                ITER_NUM   = qr_cordic_pkg::ITER_NUM,
    parameter int                K_WIDTH    = qr_cordic_pkg::K_WIDTH,
    parameter logic [K_WIDTH-1:0] K         = qr_cordic_pkg::K
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         valid_i,
    input  logic signed [DATA_WIDTH-1:0] a_ij,
    input  logic                         d_valid_i,
    input  logic        [D_WIDTH-1:0]    d_i,
    output logic                         busy_o,
    output logic                         valid_o,
    output logic signed [DATA_WIDTH-1:0] a_o,
    output logic signed [DATA_WIDTH-1:0] rij_o,
    output logic                         d_valid_o,
    output logic        [D_WIDTH-1:0]    d_o
);
    import qr_cordic_pkg::*;

    localparam int NUM_BEATS = ITER_NUM / D_WIDTH;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int SHIFT_W   = (ITER_NUM > 1) ? $clog2(ITER_NUM) : 1;
    localparam int PROD_W    = DATA_WIDTH + K_WIDTH;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    cordic_state_e                state_q, state_d;
    logic                         first_done_q, first_done_d;
    logic        [BEAT_W-1:0]     beat_q, beat_d;
    logic signed [DATA_WIDTH-1:0] x_q, x_d;
    logic signed [DATA_WIDTH-1:0] y_q, y_d;
    logic signed [DATA_WIDTH-1:0] r_q, r_d;
    logic signed [DATA_WIDTH-1:0] a_o_q, a_o_d;
    logic                         valid_o_q, valid_o_d;
    logic        [D_WIDTH-1:0]    d_o_q;
    logic                         d_valid_o_q;

    logic signed [DATA_WIDTH-1:0] x_chain [D_WIDTH+1];
    logic signed [DATA_WIDTH-1:0] y_chain [D_WIDTH+1];

    // v * K (K zero-extended) in Q.10, back to integer scale, clamped.
    function automatic logic signed [DATA_WIDTH-1:0] scale_k(
        input logic signed [DATA_WIDTH-1:0] v
    );
        logic signed [PROD_W-1:0] v_ext;
        logic signed [PROD_W-1:0] k_ext;
        logic signed [PROD_W-1:0] prod;
        logic signed [PROD_W-1:0] shifted;
        v_ext   = {{K_WIDTH{v[DATA_WIDTH-1]}}, v};
        k_ext   = {{DATA_WIDTH{1'b0}}, K};
        prod    = v_ext * k_ext;
        shifted = prod >>> (K_WIDTH - 1);
        if (shifted[PROD_W-1:DATA_WIDTH-1] ==
            {(PROD_W-DATA_WIDTH+1){shifted[PROD_W-1]}}) begin
            return shifted[DATA_WIDTH-1:0];
        end
        return shifted[PROD_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                 : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    endfunction

    assign x_chain[0] = x_q;
    assign y_chain[0] = y_q;

    // Stage j of the current beat performs iteration D_WIDTH*beat + j.
    for (genvar j = 0; j < D_WIDTH; j++) begin : g_stage
        cordic_rot_stage #(.DATA_WIDTH(DATA_WIDTH), .SHIFT_W(SHIFT_W)) u_stage (
            .x_i     (x_chain[j]),
            .y_i     (y_chain[j]),
            .d_i     (d_i[j]),
            .shift_i (SHIFT_W'(32'(beat_q) * D_WIDTH + j)),
            .x_o     (x_chain[j+1]),
            .y_o     (y_chain[j+1])
        );
    end

    always_comb begin
        state_d      = state_q;
        first_done_d = first_done_q;
        beat_d       = beat_q;
        x_d          = x_q;
        y_d          = y_q;
        r_d          = r_q;
        a_o_d        = a_o_q;
        valid_o_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    if (!first_done_q) begin
                        r_d          = a_ij;
                        first_done_d = 1'b1;
                    end else begin
                        x_d     = r_q;
                        y_d     = a_ij;
                        beat_d  = '0;
                        state_d = ST_ROT;
                    end
                end
            end
            ST_ROT: begin
                if (d_valid_i) begin
                    x_d    = x_chain[D_WIDTH];
                    y_d    = y_chain[D_WIDTH];
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        r_d       = scale_k(x_chain[D_WIDTH]);
                        a_o_d     = scale_k(y_chain[D_WIDTH]);
                        valid_o_d = 1'b1;
                        beat_d    = '0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear overrides everything, including a sample in the same cycle.
        if (clr_i) begin
            state_d      = ST_IDLE;
            first_done_d = 1'b0;
            r_d          = '0;
            valid_o_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            first_done_q <= 1'b0;
            beat_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            r_q          <= '0;
            a_o_q        <= '0;
            valid_o_q    <= 1'b0;
            d_o_q        <= '0;
            d_valid_o_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            first_done_q <= first_done_d;
            beat_q       <= beat_d;
            x_q          <= x_d;
            y_q          <= y_d;
            r_q          <= r_d;
            a_o_q        <= a_o_d;
            valid_o_q    <= valid_o_d;
            d_o_q        <= d_i;
            d_valid_o_q  <= d_valid_i;
        end
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign valid_o   = valid_o_q;
    assign a_o       = a_o_q;
    assign rij_o     = r_q;
    assign d_o       = d_o_q;
    assign d_valid_o = d_valid_o_q;

endmodule

// File: doc/gr_cell.md
# gr_cell

Givens-rotation (GR) cell for the CORDIC QR systolic array. It sits directly downstream of the GG vectoring cell in the same row. It consumes the per-iteration rotation-direction bits that GG emits, four per cycle, and applies the same 12 micro-rotations to the pair (stored r_ij, incoming a_ij). It outputs the K-scaled rotated element to the row below, keeps the updated r_ij, and forwards the direction bits one cycle later to the next GR cell to the right.

## Interface
Parameters:
- DATA_WIDTH, 20, signed two's-complement data width
- D_WIDTH, 4, direction bits per beat (unfolding factor)
- ITER_NUM, 12, total micro-rotations; must be a multiple of D_WIDTH
- K_WIDTH, 11, width of the CORDIC gain constant
- K, 11'b0_1001101101, gain constant, unsigned Q1.10 (621/1024)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- clr_i  in  1  synchronous clear: drops stored r and the first-sample flag
- valid_i  in  1  a_ij valid for one cycle
- a_ij  in  DATA_WIDTH  signed element from the row above
- d_valid_i  in  1  direction beat valid
- d_i  in  D_WIDTH  direction bits; bit j applies to iteration 4k+j
- busy_o  out  1  rotation in progress; valid_i is ignored while high
- valid_o  out  1  one-cycle pulse; a_o and rij_o are updated
- a_o  out  DATA_WIDTH  rotated, scaled y passed to the row below
- rij_o  out  DATA_WIDTH  current stored r_ij
- d_valid_o  out  1  d_valid_i delayed 1 cycle
- d_o  out  D_WIDTH  d_i delayed 1 cycle

## Operation
- FSM states: IDLE, ROT, OUT.
- IDLE, valid_i=1, first sample since rst/clr:
  - r <= a_ij.
  - No rotation, no valid_o.
  - Stay in IDLE and set first_done.
- IDLE, valid_i=1, first_done=1:
  - Load x <= r, y <= a_ij, beat counter <= 0.
  - Go to ROT.
- ROT, each cycle with d_valid_i=1:
  - Apply 4 chained micro-rotations with shift s = 4*beat + j, j = 0..3.
  - For d=1: x' = x + (y>>>s), y' = y - (x>>>s).
  - For d=0: x' = x - (y>>>s), y' = y + (x>>>s).
  - Each add is DATA_WIDTH+1 bits, then saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Increment the beat counter.
- ROT, d_valid_i=0: hold. Stalls are allowed with no limit.
- After beat ITER_NUM/D_WIDTH-1 (beat 2), go to OUT.
- OUT:
  - Compute px = x*K and py = y*K (DATA_WIDTH+K_WIDTH signed products, K zero-extended).
  - Each result = product >>> 10, saturated to DATA_WIDTH.
  - r <= sat(px), a_o <= sat(py), valid_o=1.
  - Return to IDLE.
- d_valid_i in IDLE is not consumed but is still forwarded.
- Forwarding: d_o/d_valid_o <= d_i/d_valid_i every cycle, independent of the FSM.
- busy_o = (state != IDLE).

## Timing
- Reset values:
  - state IDLE, first_done 0, r 0.
  - a_o 0, rij_o 0, valid_o 0, busy_o 0, d_o 0, d_valid_o 0.
- Latency, no stalls:
  - valid_i at cycle t, beats at t+1, t+2, t+3.
  - valid_o registered high in t+4, with a_o and rij_o valid in the same cycle.
- Throughput: one rotation per 4 cycles. valid_i at t+4 is accepted, because the FSM is back in IDLE.
- rij_o always shows r. It changes only on the first-sample load or at OUT.
- Boundary conditions:
  - clr_i and valid_i in the same cycle: clr wins, the sample is dropped, and first_done=0.
  - clr_i or rst in ROT/OUT: abort, no valid_o. rst also zeroes the outputs; clr_i zeroes only r/rij_o.
  - valid_i while busy_o=1: ignored, no state change.
  - Saturation: an intermediate value never wraps; it clamps at each of the 12 stages.

## Structure
- Shared package qr_cordic_pkg holds:
  - DATA_WIDTH, D_WIDTH, ITER_NUM, K_WIDTH, K.
  - The sat() function (DATA_WIDTH+1 -> DATA_WIDTH).
  - The FSM state enum.
- Sub-module cordic_rot_stage holds one micro-rotation: inputs x, y, d, shift; outputs saturated x', y'.
  - It uses the existing dynamic_shift for the arithmetic shift.
  - gr_cell instantiates it D_WIDTH times in a chain.
- The GG cell and gr_cell share cordic_rot_stage and the package.

## Test plan
- Reset: assert rst for 2 cycles mid-rotation -> all outputs 0, busy_o 0, and the next valid_i is treated as the first sample.
- First load: valid_i, a_ij=1000 -> no valid_o, rij_o=1000 from the next cycle.
- Rotate: r=1000, a_ij=0, d beats from the golden GG model for (1000,0), no stalls -> valid_o at t+4, rij_o within ±4 of 1000, a_o within ±4 of 0.
- Stalls: same vectors with d_valid_i dropped for 3 cycles between beats 1 and 2 -> identical a_o/rij_o, valid_o delayed by 3 cycles; d_o/d_valid_o mirror the input one cycle late throughout.
- Saturation: r=524287, a_ij=524287, d=4'b1111 on all beats -> x clamps at 524287 in iteration 0 (no wrap), outputs bit-match the saturating golden model.
- Collisions:
  - valid_i during ROT -> ignored.
  - clr_i together with valid_i -> sample dropped, rij_o=0, and the next valid_i reloads r.
